// File: rtl/alu_share_ctrl_if.sv
// Request/response and ALU-side signal bundle for alu_share_ctrl.
// slave = the controller, master = requesters plus the shared ALU.
interface alu_share_ctrl_if;
  logic        REQ0_VALID;
  logic        REQ1_VALID;
  logic        REQ0_READY;
  logic        REQ1_READY;
  logic [31:0] REQ0_OP1;
  logic [31:0] REQ0_OP2;
  logic [31:0] REQ1_OP1;
  logic [31:0] REQ1_OP2;
  logic [5:0]  REQ0_OPRN;
  logic [5:0]  REQ1_OPRN;
  logic        RSP0_VALID;
  logic        RSP1_VALID;
  logic        RSP0_READY;
  logic        RSP1_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_ZERO;
  logic        RSP_ERR;
  logic [31:0] ALU_OP1;
  logic [31:0] ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic        BUSY;

  modport slave (
    input  REQ0_VALID, REQ1_VALID,
    input  REQ0_OP1, REQ0_OP2, REQ0_OPRN,
    input  REQ1_OP1, REQ1_OP2, REQ1_OPRN,
    input  RSP0_READY, RSP1_READY,
    input  ALU_OUT, ALU_ZERO,
    output REQ0_READY, REQ1_READY,
    output RSP0_VALID, RSP1_VALID,
    output RSP_DATA, RSP_ZERO, RSP_ERR,
    output ALU_OP1, ALU_OP2, ALU_OPRN,
    output BUSY
  );

  modport master (
    output REQ0_VALID, REQ1_VALID,
    output REQ0_OP1, REQ0_OP2, REQ0_OPRN,
    output REQ1_OP1, REQ1_OP2, REQ1_OPRN,
    output RSP0_READY, RSP1_READY,
    output ALU_OUT, ALU_ZERO,
    input  REQ0_READY, REQ1_READY,
    input  RSP0_VALID, RSP1_VALID,
    input  RSP_DATA, RSP_ZERO, RSP_ERR,
    input  ALU_OP1, ALU_OP2, ALU_OPRN,
    input  BUSY
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One op in flight; operands held for a per-opcode settle time.
module alu_share_ctrl #(
  parameter int unsigned ALU_WAIT = 1,
  parameter int unsigned MUL_WAIT = 4
) (
  input logic             CLK,
  input logic             RST,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [5:0]  OP_MUL  = 6'h03;
  localparam logic [15:0] ALU_CNT = 16'(ALU_WAIT - 1);
  localparam logic [15:0] MUL_CNT = 16'(MUL_WAIT - 1);

  state_e      state_q;
  logic        ptr_q;
  logic        owner_q;
  logic        bad_q;
  logic        busy_q;
  logic [15:0] cnt_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [5:0]  oprn_q;
  logic [31:0] data_q;
  logic        zero_q;
  logic        err_q;
  logic        vld0_q;
  logic        vld1_q;

  logic        idle;
  logic        gnt1;
  logic        rdy0;
  logic        rdy1;
  logic        acc;
  logic        sup;
  logic        rsp_hs;
  logic [31:0] op1_s;
  logic [31:0] op2_s;
  logic [5:0]  oprn_s;

  // ptr_q high means requester 1 wins a tie
  assign idle   = (state_q == IDLE);
  assign gnt1   = bus.REQ1_VALID & (~bus.REQ0_VALID | ptr_q);
  assign rdy0   = RST & idle & bus.REQ0_VALID & ~gnt1;
  assign rdy1   = RST & idle & gnt1;
  assign acc    = rdy0 | rdy1;

  assign op1_s  = gnt1 ? bus.REQ1_OP1  : bus.REQ0_OP1;
  assign op2_s  = gnt1 ? bus.REQ1_OP2  : bus.REQ0_OP2;
  assign oprn_s = gnt1 ? bus.REQ1_OPRN : bus.REQ0_OPRN;
  assign sup    = (oprn_s >= 6'h01) && (oprn_s <= 6'h09);

  assign rsp_hs = owner_q ? bus.RSP1_READY : bus.RSP0_READY;

  assign bus.REQ0_READY = rdy0;
  assign bus.REQ1_READY = rdy1;
  assign bus.RSP0_VALID = vld0_q;
  assign bus.RSP1_VALID = vld1_q;
  assign bus.RSP_DATA   = data_q;
  assign bus.RSP_ZERO   = zero_q;
  assign bus.RSP_ERR    = err_q;
  assign bus.ALU_OP1    = op1_q;
  assign bus.ALU_OP2    = op2_q;
  assign bus.ALU_OPRN   = oprn_q;
  assign bus.BUSY       = busy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      oprn_q  <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            owner_q <= gnt1;
            ptr_q   <= ~gnt1;
            busy_q  <= 1'b1;
            state_q <= EXEC;
            bad_q   <= ~sup;
            // unsupported ops spend one EXEC cycle with the ALU idle
            if (sup) begin
              op1_q  <= op1_s;
              op2_q  <= op2_s;
              oprn_q <= oprn_s;
              cnt_q  <= (oprn_s == OP_MUL) ? MUL_CNT : ALU_CNT;
            end else begin
              cnt_q  <= '0;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            data_q  <= bad_q ? 32'd0 : bus.ALU_OUT;
            zero_q  <= bad_q | bus.ALU_ZERO;
            err_q   <= bad_q;
            op1_q   <= '0;
            op2_q   <= '0;
            oprn_q  <= '0;
            vld0_q  <= ~owner_q;
            vld1_q  <= owner_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU model.
// Directed vectors push expected responses; a monitor pops on handshake.
module tb_alu_share_ctrl;
  logic clk;
  logic rst;

  alu_share_ctrl_if bus ();

  alu_share_ctrl #(
    .ALU_WAIT(1),
    .MUL_WAIT(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.ALU_OUT = 32'd0;
    case (bus.ALU_OPRN)
      6'h01: bus.ALU_OUT = bus.ALU_OP1 + bus.ALU_OP2;
      6'h02: bus.ALU_OUT = bus.ALU_OP1 - bus.ALU_OP2;
      6'h03: bus.ALU_OUT = bus.ALU_OP1 * bus.ALU_OP2;
      6'h04: bus.ALU_OUT = bus.ALU_OP1 >> bus.ALU_OP2;
      6'h05: bus.ALU_OUT = bus.ALU_OP1 << bus.ALU_OP2;
      6'h06: bus.ALU_OUT = bus.ALU_OP1 & bus.ALU_OP2;
      6'h07: bus.ALU_OUT = bus.ALU_OP1 | bus.ALU_OP2;
      6'h08: bus.ALU_OUT = ~(bus.ALU_OP1 | bus.ALU_OP2);
      6'h09: bus.ALU_OUT =
        ($signed(bus.ALU_OP1) < $signed(bus.ALU_OP2)) ? 32'd1 : 32'd0;
      default: bus.ALU_OUT = 32'd0;
    endcase
  end
  assign bus.ALU_ZERO = (bus.ALU_OUT == 32'd0);

  typedef struct {
    bit          id;
    logic [31:0] d;
    logic        z;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic rdy(input bit r);
    return r ? bus.REQ1_READY : bus.REQ0_READY;
  endfunction

  function automatic logic rspv(input bit r);
    return r ? bus.RSP1_VALID : bus.RSP0_VALID;
  endfunction

  task automatic set_req(input bit r, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] op);
    if (r) begin
      bus.REQ1_VALID = v;
      bus.REQ1_OP1   = a;
      bus.REQ1_OP2   = b;
      bus.REQ1_OPRN  = op;
    end else begin
      bus.REQ0_VALID = v;
      bus.REQ0_OP1   = a;
      bus.REQ0_OP2   = b;
      bus.REQ0_OPRN  = op;
    end
  endtask

  task automatic push(input bit r, input logic [31:0] d, input logic z,
                      input logic e);
    exp_t x;
    x.id = r;
    x.d  = d;
    x.z  = z;
    x.e  = e;
    exp_q.push_back(x);
  endtask

  // returns at the accept edge
  task automatic wait_acc(input bit r);
    int t = 0;
    #1;
    while (!rdy(r) && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("req_ready", rdy(r), 1);
    chk("other_ready", rdy(!r), 0);
    @(posedge clk);
  endtask

  task automatic issue(input bit r, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] op,
                       input logic [31:0] ed, input logic ez,
                       input logic ee, input int lat, input bit drv);
    int n = 0;
    push(r, ed, ez, ee);
    @(negedge clk);
    set_req(r, 1'b1, a, b, op);
    wait_acc(r);
    @(negedge clk);
    set_req(r, 1'b0, 32'd0, 32'd0, 6'h00);
    #1;
    while (!rspv(r) && n < 60) begin
      chk("alu_oprn_exec", bus.ALU_OPRN, drv ? 32'(op) : 32'd0);
      chk("alu_op1_exec", bus.ALU_OP1, drv ? a : 32'd0);
      chk("alu_op2_exec", bus.ALU_OP2, drv ? b : 32'd0);
      chk("busy_exec", bus.BUSY, 1);
      n++;
      @(negedge clk);
      #1;
    end
    chk("latency", n, lat);
    chk("alu_oprn_resp", bus.ALU_OPRN, 0);
    chk("other_rsp_valid", rspv(!r), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && ((bus.RSP0_VALID && bus.RSP0_READY) ||
                  (bus.RSP1_VALID && bus.RSP1_READY))) begin
        chk("rsp_onehot", bus.RSP0_VALID & bus.RSP1_VALID, 0);
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_owner", bus.RSP1_VALID, e.id);
          chk("rsp_data", bus.RSP_DATA, e.d);
          chk("rsp_zero", bus.RSP_ZERO, e.z);
          chk("rsp_err", bus.RSP_ERR, e.e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, 6'h01);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'h00);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    #12;
    chk("rst_ready0", bus.REQ0_READY, 0);
    chk("rst_ready1", bus.REQ1_READY, 0);
    chk("rst_rsp0", bus.RSP0_VALID, 0);
    chk("rst_rsp1", bus.RSP1_VALID, 0);
    chk("rst_data", bus.RSP_DATA, 0);
    chk("rst_zero", bus.RSP_ZERO, 0);
    chk("rst_err", bus.RSP_ERR, 0);
    chk("rst_alu_op1", bus.ALU_OP1, 0);
    chk("rst_alu_oprn", bus.ALU_OPRN, 0);
    chk("rst_busy", bus.BUSY, 0);
    set_req(0, 1'b0, 32'd0, 32'd0, 6'h00);
    @(negedge clk);
    rst = 1'b1;

    issue(0, 32'd5, 32'd7, 6'h01, 32'd12, 1'b0, 1'b0, 1, 1'b1);
    issue(1, 32'd3, 32'd4, 6'h03, 32'd12, 1'b0, 1'b0, 4, 1'b1);
    issue(0, 32'd1, 32'd2, 6'h09, 32'd1, 1'b0, 1'b0, 1, 1'b1);
    issue(1, 32'hF0, 32'd4, 6'h04, 32'h0F, 1'b0, 1'b0, 1, 1'b1);
    issue(0, 32'd7, 32'd9, 6'h0C, 32'd0, 1'b1, 1'b1, 1, 1'b0);
    issue(1, 32'd7, 32'd9, 6'h00, 32'd0, 1'b1, 1'b1, 1, 1'b0);

    bus.RSP0_READY = 1'b0;
    issue(0, 32'd9, 32'd9, 6'h02, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    push(1, 32'd2, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'd6, 32'd3, 6'h06);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", bus.RSP0_VALID, 1);
      chk("bp_data", bus.RSP_DATA, 0);
      chk("bp_zero", bus.RSP_ZERO, 1);
      chk("bp_ready1", bus.REQ1_READY, 0);
    end
    bus.RSP0_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", bus.BUSY, 0);
    chk("bp_ready1_after", bus.REQ1_READY, 1);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'h00);
    n = 0;
    while (!bus.RSP1_VALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_req1_rsp", bus.RSP1_VALID, 1);

    @(negedge clk);
    set_req(0, 1'b1, 32'd7, 32'd6, 6'h03);
    wait_acc(0);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 32'd0, 6'h00);
    #1;
    chk("mr_alu_oprn", bus.ALU_OPRN, 32'h03);
    @(negedge clk);
    chk("mr_alu_op1", bus.ALU_OP1, 32'd7);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_busy", bus.BUSY, 0);
    chk("mr_alu_oprn0", bus.ALU_OPRN, 0);
    chk("mr_alu_op10", bus.ALU_OP1, 0);
    chk("mr_rsp0", bus.RSP0_VALID, 0);
    @(negedge clk);
    rst = 1'b1;

    push(0, 32'd7, 1'b0, 1'b0);
    push(1, 32'd15, 1'b0, 1'b0);
    push(0, 32'd7, 1'b0, 1'b0);
    push(1, 32'd15, 1'b0, 1'b0);
    set_req(0, 1'b1, 32'd10, 32'd3, 6'h02);
    set_req(1, 1'b1, 32'd20, 32'd5, 6'h02);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.REQ0_READY || bus.REQ1_READY) && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", bus.REQ1_READY, 32'(g % 2));
      chk("rr_onehot", bus.REQ0_READY & bus.REQ1_READY, 0);
      @(posedge clk);
      @(negedge clk);
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 6'h00);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'h00);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
